uart_msg_rx: RTL and testbench

UART_MSG_RX -- requirements
Module: uart_msg_rx

---
 rtl/uart_msg_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_msg_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: 8N1 UART receiver feeding a fixed 16-byte message matcher.
// Optional macro RX_FRAME_CHECK_EN adds o_frame_err and stop-bit checking.
`default_nettype none

module uart_msg_rx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic       o_rx_stb,
    output logic [7:0] o_rx_data,
    output logic       o_msg_done,
    output logic       o_err,
    output logic [7:0] o_msg_count,
`ifdef RX_FRAME_CHECK_EN
    output logic       o_frame_err,
`endif
    output logic       o_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [23:0] HALF_RELOAD = (CLOCKS_PER_BAUD / 24'd2) - 24'd1;
    localparam logic [23:0] FULL_RELOAD = CLOCKS_PER_BAUD - 24'd1;

    logic        sync_meta;
    logic        sync_rx;
    logic [1:0]  state;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [3:0]  match_idx;
    logic        sample;

    function automatic logic [7:0] table_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    table_byte = 8'h48; // H
            4'd1:    table_byte = 8'h65; // e
            4'd2:    table_byte = 8'h6C; // l
            4'd3:    table_byte = 8'h6C; // l
            4'd4:    table_byte = 8'h6F; // o
            4'd5:    table_byte = 8'h2C; // ,
            4'd6:    table_byte = 8'h20;
            4'd7:    table_byte = 8'h57; // W
            4'd8:    table_byte = 8'h6F; // o
            4'd9:    table_byte = 8'h72; // r
            4'd10:   table_byte = 8'h6C; // l
            4'd11:   table_byte = 8'h64; // d
            4'd12:   table_byte = 8'h21; // !
            4'd13:   table_byte = 8'h20;
            4'd14:   table_byte = 8'h0A;
            default: table_byte = 8'h0D;
        endcase
    endfunction

    assign sample = (state != IDLE) && (baud_cnt == 24'd0);
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_meta <= 1'b1;
            sync_rx   <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= 24'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            o_rx_stb  <= 1'b0;
            o_rx_data <= 8'h00;
`ifdef RX_FRAME_CHECK_EN
            o_frame_err <= 1'b0;
`endif
        end else begin
            sync_meta <= i_uart_rx;
            sync_rx   <= sync_meta;
            o_rx_stb  <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
            o_frame_err <= 1'b0;
`endif
            // Counter is free in IDLE; it only matters once a start edge is seen.
            if (state == IDLE) begin
                if (!sync_rx) begin
                    baud_cnt <= HALF_RELOAD;
                end
            end else if (baud_cnt == 24'd0) begin
                baud_cnt <= FULL_RELOAD;
            end else begin
                baud_cnt <= baud_cnt - 24'd1;
            end

            case (state)
                IDLE: begin
                    if (!sync_rx) begin
                        state <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (sync_rx) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {sync_rx, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                default: begin
                    if (sample) begin
                        state <= IDLE;
`ifdef RX_FRAME_CHECK_EN
                        if (sync_rx) begin
                            o_rx_stb  <= 1'b1;
                            o_rx_data <= shift_reg;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
`else
                        o_rx_stb  <= 1'b1;
                        o_rx_data <= shift_reg;
`endif
                    end
                end
            endcase
        end
    end

    // Matcher evaluates the byte presented by the previous cycle's strobe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            match_idx   <= 4'd0;
            o_msg_done  <= 1'b0;
            o_err       <= 1'b0;
            o_msg_count <= 8'd0;
        end else begin
            o_msg_done <= 1'b0;
            o_err      <= 1'b0;
            if (o_rx_stb) begin
                if (o_rx_data == table_byte(match_idx)) begin
                    if (match_idx == 4'd15) begin
                        o_msg_done  <= 1'b1;
                        match_idx   <= 4'd0;
                        o_msg_count <= o_msg_count + 8'd1;
                    end else begin
                        match_idx <= match_idx + 4'd1;
                    end
                end else begin
                    o_err     <= 1'b1;
                    match_idx <= (o_rx_data == 8'h48) ? 4'd1 : 4'd0;
                end
            end
`ifdef RX_FRAME_CHECK_EN
            else if (o_frame_err) begin
                match_idx <= 4'd0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_rx.sv
// tb_uart_msg_rx: directed, table-driven bench for uart_msg_rx at 16 clocks per bit.
`default_nettype none

module tb_uart_msg_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_stb;
    logic [7:0] rx_data;
    logic       msg_done;
    logic       err;
    logic [7:0] msg_count;
    logic       busy;
`ifdef RX_FRAME_CHECK_EN
    logic       frame_err;
`endif

    uart_msg_rx #(.CLOCKS_PER_BAUD(24'd16)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_uart_rx   (uart_rx),
        .o_rx_stb    (rx_stb),
        .o_rx_data   (rx_data),
        .o_msg_done  (msg_done),
        .o_err       (err),
        .o_msg_count (msg_count),
`ifdef RX_FRAME_CHECK_EN
        .o_frame_err (frame_err),
`endif
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (rx_stb === 1'b1) begin
            stb_cnt++;
            last_data = rx_data;
        end
        if (msg_done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
`ifdef RX_FRAME_CHECK_EN
        if (frame_err === 1'b1) ferr_cnt++;
`endif
    end

    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic       exp_err;
        logic       exp_done;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] msg [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(16);
        end
        uart_rx = stop_bit;
        idle(16);
        uart_rx = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(4);
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] d, input logic e,
                                input logic dn, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.data = d; v.exp_err = e; v.exp_done = dn; v.exp_count = c;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, d0, e0, f0;
        logic [7:0] c0;

        // Single "H" after reset.
        vecs.push_back(mk(1'b1, 8'h48, 1'b0, 1'b0, 8'd0));
        // Full message twice, back to back.
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++)
                vecs.push_back(mk((m == 0 && i == 0), msg[i], 1'b0, (i == 15),
                                  (i == 15) ? 8'(m + 1) : 8'(m)));
        // "Hel", a stray "H" (mismatch, resyncs to index 1), then the rest.
        vecs.push_back(mk(1'b1, 8'h48, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b0, 8'h65, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b0, 8'h6C, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b0, 8'h48, 1'b1, 1'b0, 8'd0));
        for (int i = 1; i < 16; i++)
            vecs.push_back(mk(1'b0, msg[i], 1'b0, (i == 15), (i == 15) ? 8'd1 : 8'd0));

        // Reset state.
        idle(3);
        check("rst_stb", 32'(rx_stb), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_count", 32'(msg_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(msg_done), 0);
        check("rst_err", 32'(err), 0);
`ifdef RX_FRAME_CHECK_EN
        check("rst_ferr", 32'(frame_err), 0);
`endif
        reset_n = 1'b1;
        idle(4);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            s0 = stb_cnt; d0 = done_cnt; e0 = err_cnt;
            send_byte(vecs[k].data, 1'b1);
            check("vec_stb", 32'(stb_cnt - s0), 1);
            check("vec_data", 32'(last_data), 32'(vecs[k].data));
            check("vec_err", 32'(err_cnt - e0), 32'(vecs[k].exp_err));
            check("vec_done", 32'(done_cnt - d0), 32'(vecs[k].exp_done));
            check("vec_count", 32'(msg_count), 32'(vecs[k].exp_count));
            check("vec_busy_idle", 32'(busy), 0);
        end

        // Short low glitch on an idle line: false start.
        s0 = stb_cnt; c0 = msg_count;
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(3);
        check("glitch_busy_high", 32'(busy), 1);
        idle(20);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_stb", 32'(stb_cnt - s0), 0);
        check("glitch_count", 32'(msg_count), 32'(c0));

        // Reset in the middle of bit 4 of a frame.
        s0 = stb_cnt; d0 = done_cnt; e0 = err_cnt;
        uart_rx = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            uart_rx = msg[0][i];
            idle(16);
        end
        uart_rx = msg[0][4];
        idle(5);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        uart_rx = 1'b1;
        idle(40);
        check("abort_stb", 32'(stb_cnt - s0), 0);
        check("abort_err", 32'(err_cnt - e0), 0);
        check("abort_done", 32'(done_cnt - d0), 0);
        check("abort_count", 32'(msg_count), 0);
        check("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 16; i++) send_byte(msg[i], 1'b1);
        check("abort_msg_stb", 32'(stb_cnt - s0), 16);
        check("abort_msg_done", 32'(done_cnt - d0), 1);
        check("abort_msg_err", 32'(err_cnt - e0), 0);
        check("abort_msg_count", 32'(msg_count), 1);

`ifdef RX_FRAME_CHECK_EN
        // Bad stop bit after "He": no strobe, data held, matcher restarts.
        do_reset();
        send_byte(8'h48, 1'b1);
        send_byte(8'h65, 1'b1);
        s0 = stb_cnt; e0 = err_cnt; f0 = ferr_cnt;
        send_byte(8'h48, 1'b0);
        idle(40);
        check("ferr_pulse", 32'(ferr_cnt - f0), 1);
        check("ferr_no_stb", 32'(stb_cnt - s0), 0);
        check("ferr_data_held", 32'(rx_data), 32'h65);
        check("ferr_no_err", 32'(err_cnt - e0), 0);
        send_byte(8'h48, 1'b1);
        check("ferr_next_h_err", 32'(err_cnt - e0), 0);
        check("ferr_next_h_data", 32'(last_data), 32'h48);
        send_byte(8'h65, 1'b1);
        check("ferr_next_e_err", 32'(err_cnt - e0), 0);
`else
        // Stop-bit value is ignored: a zero stop bit still yields a byte.
        do_reset();
        s0 = stb_cnt; f0 = ferr_cnt;
        send_byte(8'h48, 1'b0);
        idle(40);
        check("stop0_stb", 32'(stb_cnt - s0), 1);
        check("stop0_data", 32'(last_data), 32'h48);
        check("stop0_no_ferr", 32'(ferr_cnt - f0), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
